// File: rtl/psram_frame_writer_if.sv
// Pixel-stream and PSRAM write-bus signals of the frame writer.
// The master side is the frame writer. The slave side is its environment:
// the pixel source, the bus arbiter and the PSRAM pins.
`timescale 1ns/1ps

interface psram_frame_writer_if;
    logic        frame_start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic [22:0] MemAdr;
    logic [15:0] MemDataOut;
    logic        MemDataOE;
    logic        MemWR;
    logic        MemOE;
    logic        RamCE;
    logic        RamLB;
    logic        RamUB;
    logic        frame_done;

    modport master (
        input  frame_start, pix_valid, pix_data, mem_gnt,
        output pix_ready, mem_req, MemAdr, MemDataOut, MemDataOE,
               MemWR, MemOE, RamCE, RamLB, RamUB, frame_done
    );

    modport slave (
        output frame_start, pix_valid, pix_data, mem_gnt,
        input  pix_ready, mem_req, MemAdr, MemDataOut, MemDataOE,
               MemWR, MemOE, RamCE, RamLB, RamUB, frame_done
    );
endinterface

// File: rtl/psram_frame_writer.sv
// PSRAM frame writer: packs pairs of 8-bit palette indices into 16-bit words
// and writes each word into frame memory. The writer uses asynchronous-SRAM
// write timing and requests the shared bus from an external arbiter.
// The even pixel goes in the low byte and the odd pixel in the high byte.
// This matches the display reader.
// All outputs are registered. Their next values are decoded from next_state,
// so each pin changes on the same edge as the state it belongs to.
`timescale 1ns/1ps

module psram_frame_writer #(
    parameter logic [22:0] BASE_ADDR   = 23'd0,
    parameter int unsigned FRAME_WORDS = 153600,
    parameter int unsigned WR_CYCLES   = 2
) (
    input  logic                clk_25Mhz,
    input  logic                reset,
    psram_frame_writer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [22:0] LAST_WORD = 23'(FRAME_WORDS - 1);
    localparam int          CNT_W     = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(WR_CYCLES - 1);

    state_t state;
    state_t next_state;

    logic             half;
    logic [7:0]       low_byte;
    logic [7:0]       high_byte;
    logic [22:0]      word_idx;
    logic             restart_pending;
    logic [CNT_W-1:0] wr_cnt;

    logic        pix_ready_q,  pix_ready_d;
    logic        mem_req_q,    mem_req_d;
    logic [22:0] adr_q,        adr_d;
    logic [15:0] data_q,       data_d;
    logic        data_oe_q,    data_oe_d;
    logic        wr_n_q,       wr_n_d;
    logic        oe_n_q;
    logic        ce_n_q,       ce_n_d;
    logic        lb_n_q,       lb_n_d;
    logic        ub_n_q,       ub_n_d;
    logic        frame_done_q, frame_done_d;

    logic pix_fire;
    logic bus_active;
    logic load_bus;

    // pix_ready is high only in IDLE, so a transfer can happen only in IDLE.
    assign pix_fire = bus.pix_valid && pix_ready_q;

    // State register.
    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. A frame_start in IDLE takes the same-cycle pixel as
    // pixel 0, so that pixel never completes a word.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pix_fire && half && !bus.frame_start) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = WRITE;
            end
            WRITE: begin
                if (wr_cnt == LAST_WR) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. Address and data are loaded once, on entry to SETUP.
    // They then hold through WRITE and HOLD to cover setup and hold time.
    always_comb begin
        bus_active   = (next_state == SETUP) || (next_state == WRITE) || (next_state == HOLD);
        load_bus     = (state == REQ) && (next_state == SETUP);
        ce_n_d       = !bus_active;
        lb_n_d       = !bus_active;
        ub_n_d       = !bus_active;
        data_oe_d    = bus_active;
        wr_n_d       = (next_state != WRITE);
        mem_req_d    = (next_state != IDLE);
        pix_ready_d  = (next_state == IDLE);
        frame_done_d = (state == HOLD) && (word_idx == LAST_WORD);
        adr_d        = adr_q;
        data_d       = data_q;
        if (load_bus) begin
            adr_d  = BASE_ADDR + word_idx;
            data_d = {high_byte, low_byte};
        end
    end

    // Registered bus pins. Reset releases the bus at once, even mid-write.
    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            pix_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            adr_q        <= BASE_ADDR;
            data_q       <= 16'h0000;
            data_oe_q    <= 1'b0;
            wr_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            ce_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pix_ready_q  <= pix_ready_d;
            mem_req_q    <= mem_req_d;
            adr_q        <= adr_d;
            data_q       <= data_d;
            data_oe_q    <= data_oe_d;
            wr_n_q       <= wr_n_d;
            oe_n_q       <= 1'b1;
            ce_n_q       <= ce_n_d;
            lb_n_q       <= lb_n_d;
            ub_n_q       <= ub_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Datapath: pixel packing, write-pulse timer, word index and restart.
    // A restart requested while a word is in flight is applied when the
    // word finishes.
    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            half            <= 1'b0;
            low_byte        <= 8'h00;
            high_byte       <= 8'h00;
            word_idx        <= 23'd0;
            restart_pending <= 1'b0;
            wr_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        word_idx <= 23'd0;
                        half     <= pix_fire;
                        if (pix_fire) begin
                            low_byte <= bus.pix_data;
                        end
                    end else if (pix_fire) begin
                        if (!half) begin
                            low_byte <= bus.pix_data;
                            half     <= 1'b1;
                        end else begin
                            high_byte <= bus.pix_data;
                            half      <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (bus.frame_start) begin
                        restart_pending <= 1'b1;
                    end
                end
                SETUP: begin
                    wr_cnt <= '0;
                    if (bus.frame_start) begin
                        restart_pending <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (bus.frame_start) begin
                        restart_pending <= 1'b1;
                    end
                end
                HOLD: begin
                    restart_pending <= 1'b0;
                    if (restart_pending || bus.frame_start) begin
                        word_idx <= 23'd0;
                        half     <= 1'b0;
                    end else if (word_idx == LAST_WORD) begin
                        word_idx <= 23'd0;
                    end else begin
                        word_idx <= word_idx + 23'd1;
                    end
                end
                default: begin
                    half <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.MemAdr     = adr_q;
    assign bus.MemDataOut = data_q;
    assign bus.MemDataOE  = data_oe_q;
    assign bus.MemWR      = wr_n_q;
    assign bus.MemOE      = oe_n_q;
    assign bus.RamCE      = ce_n_q;
    assign bus.RamLB      = lb_n_q;
    assign bus.RamUB      = ub_n_q;
    assign bus.frame_done = frame_done_q;

endmodule
